// File: rtl/dot_arbiter.sv
// Round-robin arbiter sharing one matrix_dot engine among NUM_REQ requesters.
// Define DOT_TIMEOUT_EN to add a WAIT-state watchdog that answers with resp_err=1.
module dot_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int START_HOLD     = 4,
  parameter int RECOVER_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*128-1:0] req_a,
  input  logic [NUM_REQ*128-1:0] req_b,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_data,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   dot_start,
  output logic [127:0]           dot_a,
  output logic [127:0]           dot_b,
  input  logic [31:0]            dot_c,
  input  logic                   dot_done,
  output logic                   dot_rst_n
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_SR  = (START_HOLD > RECOVER_CYCLES) ? START_HOLD : RECOVER_CYCLES;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > MAX_SR) ? TIMEOUT_CYCLES : MAX_SR;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [127:0]     a_arr [NUM_REQ];
  logic [127:0]     b_arr [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      a_arr[k] = req_a[k*128 +: 128];
      b_arr[k] = req_b[k*128 +: 128];
    end
  end

  // Scan from farthest to nearest so the requester closest to rr_ptr wins.
  always_comb begin
    int j;
    logic [IDX_W-1:0] j_idx;
    j        = 0;
    j_idx    = '0;
    pick_any = 1'b0;
    pick_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_idx = IDX_W'(j);
      if (req[j_idx]) begin
        pick_any = 1'b1;
        pick_idx = j_idx;
      end
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      gnt        <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      dot_start  <= 1'b0;
      dot_a      <= '0;
      dot_b      <= '0;
      dot_rst_n  <= 1'b0;
`ifdef DOT_TIMEOUT_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      resp_valid <= '0;
      dot_rst_n  <= 1'b1;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            gnt       <= NUM_REQ'(1) << pick_idx;
            gnt_idx   <= pick_idx;
            dot_a     <= a_arr[pick_idx];
            dot_b     <= b_arr[pick_idx];
            dot_start <= 1'b1;
            cnt       <= '0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (cnt == CNT_W'(START_HOLD - 1)) begin
            dot_start <= 1'b0;
            cnt       <= '0;
            state     <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (dot_done) begin
            resp_data  <= dot_c;
            resp_valid <= gnt;
`ifdef DOT_TIMEOUT_EN
            resp_err   <= 1'b0;
`endif
            state      <= S_RESP;
          end
`ifdef DOT_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            resp_data  <= '0;
            resp_valid <= gnt;
            resp_err   <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          gnt       <= '0;
          rr_ptr    <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          dot_rst_n <= 1'b0;
          cnt       <= '0;
          state     <= S_RECOVER;
        end
        S_RECOVER: begin
          // dot_rst_n falls back to its default high on the exit edge.
          if (cnt == CNT_W'(RECOVER_CYCLES - 1)) begin
            state <= S_IDLE;
          end else begin
            dot_rst_n <= 1'b0;
            cnt       <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef DOT_TIMEOUT_EN
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dot_arbiter.sv
// Self-checking bench for dot_arbiter with a behavioural matrix_dot engine stub.
// The timeout scenario runs only when DOT_TIMEOUT_EN is defined.
module tb_dot_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ENG_LAT = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_REQ-1:0]     req = '0;
  logic [NUM_REQ*128-1:0] req_a = '0;
  logic [NUM_REQ*128-1:0] req_b = '0;
  logic [NUM_REQ-1:0]     gnt;
  logic [NUM_REQ-1:0]     resp_valid;
  logic [31:0]            resp_data;
  logic                   resp_err;
  logic                   busy;
  logic                   dot_start;
  logic [127:0]           dot_a;
  logic [127:0]           dot_b;
  logic [31:0]            dot_c = '0;
  logic                   dot_done = 1'b0;
  logic                   dot_rst_n;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t q[$];
  exp_t e;

  bit early_done = 1'b0;
  bit hang = 1'b0;
  logic eng_run = 1'b0;
  int eng_cnt = 0;
  int st_cnt = 0;

  dot_arbiter #(
    .NUM_REQ(NUM_REQ), .START_HOLD(4), .RECOVER_CYCLES(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .dot_start(dot_start), .dot_a(dot_a), .dot_b(dot_b),
    .dot_c(dot_c), .dot_done(dot_done), .dot_rst_n(dot_rst_n)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] calc(input logic [127:0] a, input logic [127:0] b);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s += a[i*8 +: 8] * b[i*8 +: 8];
    return s;
  endfunction

  // Engine stub: optional bogus done pulse during START, real result ENG_LAT cycles after START.
  always @(posedge clk) begin
    if (dot_rst_n === 1'b0) begin
      eng_run  <= 1'b0;
      eng_cnt  <= 0;
      st_cnt   <= 0;
      dot_done <= 1'b0;
    end else if (dot_start === 1'b1) begin
      eng_run <= 1'b1;
      eng_cnt <= 0;
      st_cnt  <= st_cnt + 1;
      if (early_done && st_cnt == 0) begin
        dot_done <= 1'b1;
        dot_c    <= 32'hBAD0BAD0;
      end else begin
        dot_done <= 1'b0;
      end
    end else if (eng_run && !hang) begin
      if (eng_cnt == ENG_LAT - 1) begin
        dot_done <= 1'b1;
        dot_c    <= calc(dot_a, dot_b);
        eng_run  <= 1'b0;
        st_cnt   <= 0;
      end else begin
        eng_cnt  <= eng_cnt + 1;
        dot_done <= 1'b0;
      end
    end else begin
      dot_done <= 1'b0;
    end
  end

  // Scoreboard consumer: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && resp_valid !== '0) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpected_resp got=%b required=none", resp_valid);
      end else begin
        e = q.pop_front();
        checks++;
        if (resp_valid !== e.vld) begin
          failures++; $display("[TB] FAIL resp_valid got=%b required=%b", resp_valid, e.vld);
        end
        checks++;
        if (resp_data !== e.data) begin
          failures++; $display("[TB] FAIL resp_data got=%0d required=%0d", resp_data, e.data);
        end
        checks++;
        if (resp_err !== e.err) begin
          failures++; $display("[TB] FAIL resp_err got=%b required=%b", resp_err, e.err);
        end
        checks++;
        if (gnt !== e.vld) begin
          failures++; $display("[TB] FAIL gnt_at_resp got=%b required=%b", gnt, e.vld);
        end
      end
    end
  end

  task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
    req_a[k*128 +: 128] = {16{a}};
    req_b[k*128 +: 128] = {16{b}};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_busy(output bit to);
    to = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (busy === 1'b1) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_start_low(output bit to);
    to = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (dot_start === 1'b0) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic run_until_idle(output int sh, output int rl, output bit to);
    sh = 0; rl = 0; to = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (dot_start === 1'b1) sh++;
      if (dot_rst_n === 1'b0) rl++;
      if (busy === 1'b0) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, resp_valid, resp_err, busy, dot_start, dot_rst_n} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b required=0",
               {gnt, resp_valid, resp_err, busy, dot_start, dot_rst_n});
    end
    checks++;
    if ({resp_data, dot_a, dot_b} !== '0) begin
      failures++; $display("[TB] FAIL reset_data got=%h required=0", {resp_data, dot_a, dot_b});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dot_rst_n !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_release_rstn got=%b required=1", dot_rst_n);
    end
  endtask

  task automatic test_single();
    int sh, rl; bit to;
    set_ops(0, 8'd1, 8'd1);
    q.push_back('{vld: 4'b0001, data: 32'd16, err: 1'b0});
    req = 4'b0001;
    wait_busy(to);
    req = 4'b0000;
    checks++;
    if (to || gnt !== 4'b0001) begin
      failures++; $display("[TB] FAIL single_gnt got=%b required=0001 timeout=%0d", gnt, to);
    end
    run_until_idle(sh, rl, to);
    checks++;
    if (to || sh != 4) begin
      failures++; $display("[TB] FAIL single_start_len got=%0d required=4 timeout=%0d", sh, to);
    end
    checks++;
    if (rl != 4) begin
      failures++; $display("[TB] FAIL single_recover_len got=%0d required=4", rl);
    end
    checks++;
    if (q.size() != 0) begin
      failures++; $display("[TB] FAIL single_resp_missing got=%0d required=0", q.size());
    end
  endtask

  task automatic test_round_robin();
    int sh, rl; bit to;
    logic [3:0] want;
    for (int k = 0; k < NUM_REQ; k++) set_ops(k, 8'(k + 1), 8'(k + 1));
    for (int op = 0; op < 5; op++)
      q.push_back('{vld: 4'b0001 << (op % 4), data: 32'(16 * ((op % 4) + 1) * ((op % 4) + 1)), err: 1'b0});
    req = 4'b1111;
    for (int op = 0; op < 5; op++) begin
      want = 4'b0001 << (op % 4);
      wait_busy(to);
      if (op == 4) req = 4'b0000;
      checks++;
      if (to || gnt !== want) begin
        failures++; $display("[TB] FAIL rr_gnt op=%0d got=%b required=%b timeout=%0d", op, gnt, want, to);
      end
      run_until_idle(sh, rl, to);
      checks++;
      if (to) begin
        failures++; $display("[TB] FAIL rr_idle op=%0d got=busy required=idle", op);
      end
    end
    checks++;
    if (q.size() != 0) begin
      failures++; $display("[TB] FAIL rr_resp_missing got=%0d required=0", q.size());
    end
  endtask

  task automatic test_req_drop();
    int sh, rl; bit to;
    set_ops(2, 8'd3, 8'd2);
    q.push_back('{vld: 4'b0100, data: 32'd96, err: 1'b0});
    req = 4'b0100;
    wait_busy(to);
    checks++;
    if (to || gnt !== 4'b0100) begin
      failures++; $display("[TB] FAIL drop_gnt got=%b required=0100 timeout=%0d", gnt, to);
    end
    wait_start_low(to);
    req_a[2*128 +: 128] = {16{8'hFF}};
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (to || dot_a !== {16{8'h03}}) begin
      failures++; $display("[TB] FAIL drop_dot_a_stable got=%h required=%h", dot_a, {16{8'h03}});
    end
    run_until_idle(sh, rl, to);
    checks++;
    if (to || q.size() != 0) begin
      failures++; $display("[TB] FAIL drop_resp_missing got=%0d required=0 timeout=%0d", q.size(), to);
    end
  endtask

  task automatic test_max_operands();
    int sh, rl; bit to;
    set_ops(1, 8'hFF, 8'hFF);
    q.push_back('{vld: 4'b0010, data: 32'd1040400, err: 1'b0});
    req = 4'b0010;
    wait_busy(to);
    req = 4'b0000;
    checks++;
    if (to || gnt !== 4'b0010) begin
      failures++; $display("[TB] FAIL max_gnt got=%b required=0010 timeout=%0d", gnt, to);
    end
    run_until_idle(sh, rl, to);
    checks++;
    if (to || q.size() != 0) begin
      failures++; $display("[TB] FAIL max_resp_missing got=%0d required=0 timeout=%0d", q.size(), to);
    end
  endtask

  task automatic test_early_done();
    int sh, rl; bit to;
    set_ops(0, 8'd2, 8'd5);
    early_done = 1'b1;
    q.push_back('{vld: 4'b0001, data: 32'd160, err: 1'b0});
    req = 4'b0001;
    wait_busy(to);
    req = 4'b0000;
    run_until_idle(sh, rl, to);
    early_done = 1'b0;
    checks++;
    if (to || q.size() != 0) begin
      failures++; $display("[TB] FAIL early_done_resp got=%0d required=0 timeout=%0d", q.size(), to);
    end
  endtask

  task automatic test_reset_mid_op();
    int sh, rl; bit to;
    set_ops(0, 8'd1, 8'd1);
    set_ops(3, 8'd2, 8'd2);
    hang = 1'b1;
    req = 4'b0100;
    wait_busy(to);
    req = 4'b0000;
    wait_start_low(to);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (to || {gnt, resp_valid, busy, dot_start, dot_rst_n} !== '0 || dot_a !== '0) begin
      failures++;
      $display("[TB] FAIL midrst_outputs got=%b required=0 timeout=%0d",
               {gnt, resp_valid, busy, dot_start, dot_rst_n}, to);
    end
    rst = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    checks++;
    if (dot_rst_n !== 1'b1) begin
      failures++; $display("[TB] FAIL midrst_rstn_release got=%b required=1", dot_rst_n);
    end
    repeat (10) @(negedge clk);
    q.push_back('{vld: 4'b0001, data: 32'd16, err: 1'b0});
    req = 4'b1001;
    wait_busy(to);
    req = 4'b0000;
    checks++;
    if (to || gnt !== 4'b0001) begin
      failures++; $display("[TB] FAIL midrst_regrant got=%b required=0001 timeout=%0d", gnt, to);
    end
    run_until_idle(sh, rl, to);
    checks++;
    if (to || q.size() != 0) begin
      failures++; $display("[TB] FAIL midrst_resp got=%0d required=0 timeout=%0d", q.size(), to);
    end
  endtask

`ifdef DOT_TIMEOUT_EN
  task automatic test_timeout();
    int sh, rl, n; bit to;
    set_ops(0, 8'd1, 8'd1);
    hang = 1'b1;
    q.push_back('{vld: 4'b0001, data: 32'd0, err: 1'b1});
    req = 4'b0001;
    wait_busy(to);
    req = 4'b0000;
    wait_start_low(to);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (resp_valid !== '0) break;
    end
    checks++;
    if (to || n != 8) begin
      failures++; $display("[TB] FAIL timeout_latency got=%0d required=8", n);
    end
    run_until_idle(sh, rl, to);
    hang = 1'b0;
    checks++;
    if (to || q.size() != 0) begin
      failures++; $display("[TB] FAIL timeout_resp got=%0d required=0 timeout=%0d", q.size(), to);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    do_reset();
    test_round_robin();
    test_req_drop();
    test_max_operands();
    test_early_done();
    test_reset_mid_op();
`ifdef DOT_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
